mem_stage_hs: RTL and testbench

- Next-generation MEM pipeline stage for the 5-stage MIPS core. Sits between the EX/MEM register and WB.
- Adds over the previous stage:
  - a request/grant/response handshake to data memory, so latency is variable;
  - store byte-enable and write-data lane steering;
  - full load extension: lb, lbu, lh, lhu, lw;
  - a response-timeout watchdog;
  - flush handling;
  - a forwarding/hazard interface that also flags loads still in flight.

---
 rtl/mem_stage_hs_if.sv | 24 ++
 rtl/mem_stage_hs.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_hs_if.sv
// mem_stage_hs_if: data-memory request/grant/response bus.
// master = MEM stage, slave = memory.
interface mem_stage_hs_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_byteen;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MIPS MEM stage, req/gnt/rvalid memory, load extend, watchdog.
// Optional MEM_ALIGN_CHK_EN traps misaligned lw/sw/lh/lhu/sh with mem_err.
module mem_stage_hs #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] WB_RST_PC = 32'h0000_3000,
    parameter int          MAX_WAIT  = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           m_valid,
    input  logic [31:0]    m_pc,
    input  logic [31:0]    m_instr,
    input  logic [31:0]    m_addr,
    input  logic [31:0]    m_wdata,
    input  logic           flush,
    mem_stage_hs_if.master mem,
    output logic           stall,
    output logic           fwd_valid,
    output logic           fwd_pend,
    output logic [4:0]     fwd_addr,
    output logic [31:0]    fwd_data,
    output logic           wb_valid,
    output logic [31:0]    wb_pc,
    output logic [31:0]    wb_instr,
    output logic [31:0]    wb_mem_data,
    output logic [31:0]    wb_alu_data,
    output logic           mem_err
);
    localparam int CW = 17;

    typedef enum logic [1:0] {IDLE, WAIT_RSP, DRAIN} st_t;

    st_t           state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    logic        wb_valid_q;
    logic [31:0] wb_pc_q, wb_instr_q, wb_mem_q, wb_alu_q;

    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    assign op = m_instr[31:26];
    assign fn = m_instr[5:0];
    assign rs = m_instr[25:21];
    assign rt = m_instr[20:16];
    assign rd = m_instr[15:11];

    logic is_lb, is_lh, is_lw, is_lbu, is_lhu;
    logic is_sb, is_sh, is_sw;
    logic is_load, is_store, op_mem;
    logic alu_rd, alu_rt, is_jal;

    assign is_lb  = op == 6'h20;
    assign is_lh  = op == 6'h21;
    assign is_lw  = op == 6'h23;
    assign is_lbu = op == 6'h24;
    assign is_lhu = op == 6'h25;
    assign is_sb  = op == 6'h28;
    assign is_sh  = op == 6'h29;
    assign is_sw  = op == 6'h2B;

    assign is_load  = is_lb | is_lh | is_lw | is_lbu | is_lhu;
    assign is_store = is_sb | is_sh | is_sw;
    assign op_mem   = is_load | is_store;

    assign alu_rd = (op == 6'h00) &
                    ((fn == 6'h20) | (fn == 6'h22) |
                     (fn == 6'h24) | (fn == 6'h25) |
                     (fn == 6'h2A) | (fn == 6'h2B) |
                     (fn == 6'h10) | (fn == 6'h12));
    assign alu_rt = (op == 6'h08) | (op == 6'h0C) |
                    (op == 6'h0D) | (op == 6'h0F) |
                    ((op == 6'h10) & (rs == 5'd0));
    assign is_jal = op == 6'h03;

    logic misal;
`ifdef MEM_ALIGN_CHK_EN
    assign misal = ((is_lw | is_sw) & (m_addr[1:0] != 2'b00)) |
                   ((is_lh | is_lhu | is_sh) & m_addr[0]);
`else
    assign misal = 1'b0;
`endif

    logic active, issue, tmo, drain_tmo;
    assign active    = m_valid & ~flush;
    assign issue     = (state_q == IDLE) & active & op_mem & ~misal;
    assign cnt_inc   = cnt_q + CW'(1);
    assign tmo       = cnt_inc == CW'(MAX_WAIT);
    assign drain_tmo = cnt_inc >= CW'(MAX_WAIT);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;

    always_comb begin
        ld_b = mem.mem_rdata[7:0];
        unique case (m_addr[1:0])
            2'd0: ld_b = mem.mem_rdata[7:0];
            2'd1: ld_b = mem.mem_rdata[15:8];
            2'd2: ld_b = mem.mem_rdata[23:16];
            2'd3: ld_b = mem.mem_rdata[31:24];
            default: ld_b = mem.mem_rdata[7:0];
        endcase
        ld_h   = m_addr[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        ld_ext = '0;
        unique case (1'b1)
            is_lw:   ld_ext = mem.mem_rdata;
            is_lh:   ld_ext = {{16{ld_h[15]}}, ld_h};
            is_lhu:  ld_ext = {16'h0, ld_h};
            is_lb:   ld_ext = {{24{ld_b[7]}}, ld_b};
            is_lbu:  ld_ext = {24'h0, ld_b};
            default: ld_ext = '0;
        endcase
    end

    logic [3:0]  be;
    logic [31:0] wd;

    always_comb begin
        be = 4'b0000;
        wd = '0;
        unique case (1'b1)
            is_sw: begin
                be = 4'b1111;
                wd = m_wdata;
            end
            is_sh: begin
                be = m_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{m_wdata[15:0]}};
            end
            is_sb: begin
                be = 4'b0001 << m_addr[1:0];
                wd = {4{m_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    logic        f_valid, f_pend;
    logic [4:0]  f_addr;
    logic [31:0] f_data;

    always_comb begin
        f_valid = 1'b0;
        f_pend  = 1'b0;
        f_addr  = 5'd0;
        f_data  = '0;
        unique case (1'b1)
            alu_rd: begin
                f_valid = m_valid;
                f_data  = m_addr;
                f_addr  = rd;
            end
            alu_rt: begin
                f_valid = m_valid;
                f_data  = m_addr;
                f_addr  = rt;
            end
            is_jal: begin
                f_valid = m_valid;
                f_data  = m_addr;
                f_addr  = 5'd31;
            end
            is_load: begin
                f_pend = m_valid;
                f_addr = rt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (issue & is_load & mem.mem_gnt)
                    state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                cnt_d = cnt_inc;
                if (flush) begin
                    state_d = DRAIN;
                end else if (mem.mem_rvalid | tmo) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_inc;
                if (mem.mem_rvalid | drain_tmo) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic        complete, err;
    logic [31:0] mdat_d;

    always_comb begin
        complete = 1'b0;
        err      = 1'b0;
        mdat_d   = '0;
        unique case (state_q)
            IDLE: begin
                complete = active &
                           (~op_mem | misal | (is_store & mem.mem_gnt));
                err      = active & op_mem & misal;
            end
            WAIT_RSP: begin
                complete = active & (mem.mem_rvalid | tmo);
                err      = active & ~mem.mem_rvalid & tmo;
                mdat_d   = mem.mem_rvalid ? ld_ext : '0;
            end
            default: ;
        endcase
    end

    // Every combinational output is forced low while reset is held.
    logic req_on;
    assign req_on = rst & issue;

    assign mem.mem_req    = req_on;
    assign mem.mem_we     = req_on & is_store;
    assign mem.mem_addr   = req_on ? {m_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem.mem_byteen = req_on ? be : 4'b0000;
    assign mem.mem_wdata  = (req_on & is_store) ? wd : '0;

    assign stall = rst & ((m_valid & ~flush & ~complete) |
                          (state_q == DRAIN));
    assign fwd_valid = rst & f_valid;
    assign fwd_pend  = rst & f_pend;
    assign fwd_addr  = rst ? f_addr : 5'd0;
    assign fwd_data  = rst ? f_data : '0;
    assign mem_err   = rst & err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q <= 1'b0;
            wb_pc_q    <= WB_RST_PC;
            wb_instr_q <= '0;
            wb_mem_q   <= '0;
            wb_alu_q   <= '0;
        end else begin
            wb_valid_q <= complete;
            if (complete) begin
                wb_pc_q    <= m_pc;
                wb_instr_q <= m_instr;
                wb_mem_q   <= mdat_d;
                wb_alu_q   <= m_addr;
            end
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_pc       = wb_pc_q;
    assign wb_instr    = wb_instr_q;
    assign wb_mem_data = wb_mem_q;
    assign wb_alu_data = wb_alu_q;
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed stimulus; WB results go through a scoreboard
// queue checked by an independent monitor.
module tb_mem_stage_hs;
    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid;
    logic [31:0] m_pc, m_instr, m_addr, m_wdata;
    logic        flush;
    logic        stall, fwd_valid, fwd_pend;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        wb_valid;
    logic [31:0] wb_pc, wb_instr, wb_mem_data, wb_alu_data;
    logic        mem_err;

    always #5 clk = ~clk;

    mem_stage_hs_if #(.ADDR_W(32)) mif ();

    mem_stage_hs #(
        .ADDR_W(32),
        .WB_RST_PC(32'h0000_3000),
        .MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m_valid(m_valid),
        .m_pc(m_pc),
        .m_instr(m_instr),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .flush(flush),
        .mem(mif.master),
        .stall(stall),
        .fwd_valid(fwd_valid),
        .fwd_pend(fwd_pend),
        .fwd_addr(fwd_addr),
        .fwd_data(fwd_data),
        .wb_valid(wb_valid),
        .wb_pc(wb_pc),
        .wb_instr(wb_instr),
        .wb_mem_data(wb_mem_data),
        .wb_alu_data(wb_alu_data),
        .mem_err(mem_err)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] mdat;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] alu, input logic [31:0] md);
        exp_t e;
        e.pc = pc;
        e.instr = ins;
        e.alu = alu;
        e.mdat = md;
        sbq.push_back(e);
    endtask

    task automatic drv(input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] wd);
        m_valid = v;
        m_pc    = pc;
        m_instr = ins;
        m_addr  = a;
        m_wdata = wd;
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected got pc=%h want none", wb_pc);
            end else begin
                mon_e = sbq.pop_front();
                chk("wb_pc", wb_pc, mon_e.pc);
                chk("wb_instr", wb_instr, mon_e.instr);
                chk("wb_alu", wb_alu_data, mon_e.alu);
                chk("wb_mem", wb_mem_data, mon_e.mdat);
            end
        end
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata = 32'h0;
        #1 rst = 1'b0;
        drv(1'b1, 32'h200, 32'h8C03_0004, 32'h4, 32'h0);
        neg();
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_wb_pc", wb_pc, 32'h0000_3000);
        chk("rst_wb_alu", wb_alu_data, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_req", 32'(mif.mem_req), 32'h0);
        chk("rst_pend", 32'(fwd_pend), 32'h0);
        chk("rst_faddr", 32'(fwd_addr), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        drv(1'b1, 32'h100, 32'h34A5_0001, 32'h1, 32'h0);
        push(32'h100, 32'h34A5_0001, 32'h1, 32'h0);
        neg();
        chk("ori_faddr", 32'(fwd_addr), 32'd5);
        chk("ori_fvalid", 32'(fwd_valid), 32'h1);
        chk("ori_fdata", fwd_data, 32'h1);
        chk("ori_stall", 32'(stall), 32'h0);
        chk("ori_req", 32'(mif.mem_req), 32'h0);

        nx();
        drv(1'b1, 32'h104, 32'h0085_3820, 32'h55, 32'h0);
        push(32'h104, 32'h0085_3820, 32'h55, 32'h0);
        neg();
        chk("add_faddr", 32'(fwd_addr), 32'd7);
        chk("add_fdata", fwd_data, 32'h55);

        nx();
        drv(1'b1, 32'h108, 32'h0C00_0010, 32'h10C, 32'h0);
        push(32'h108, 32'h0C00_0010, 32'h10C, 32'h0);
        neg();
        chk("jal_faddr", 32'(fwd_addr), 32'd31);

        nx();
        drv(1'b1, 32'h10C, 32'hA002_0000, 32'h1002, 32'hAB);
        mif.mem_gnt = 1'b1;
        push(32'h10C, 32'hA002_0000, 32'h1002, 32'h0);
        neg();
        chk("sb_req", 32'(mif.mem_req), 32'h1);
        chk("sb_we", 32'(mif.mem_we), 32'h1);
        chk("sb_be", 32'(mif.mem_byteen), 32'h4);
        chk("sb_wdata", mif.mem_wdata, 32'hABAB_ABAB);
        chk("sb_addr", mif.mem_addr, 32'h1000);
        chk("sb_stall", 32'(stall), 32'h0);

        nx();
        drv(1'b1, 32'h110, 32'hA402_0000, 32'h1002, 32'h1234_CDEF);
        push(32'h110, 32'hA402_0000, 32'h1002, 32'h0);
        neg();
        chk("sh_be", 32'(mif.mem_byteen), 32'hC);
        chk("sh_wdata", mif.mem_wdata, 32'hCDEF_CDEF);

        nx();
        drv(1'b1, 32'h114, 32'hAC02_0000, 32'h2005, 32'hDEAD_BEEF);
        mif.mem_gnt = 1'b0;
        push(32'h114, 32'hAC02_0000, 32'h2005, 32'h0);
        neg();
        chk("sw_wait_stall", 32'(stall), 32'h1);
        chk("sw_wait_req", 32'(mif.mem_req), 32'h1);
        chk("sw_be", 32'(mif.mem_byteen), 32'hF);
        chk("sw_addr", mif.mem_addr, 32'h2004);
        nx();
        mif.mem_gnt = 1'b1;
        neg();
        chk("sw_gnt_stall", 32'(stall), 32'h0);

        nx();
        drv(1'b1, 32'h118, 32'h8003_0000, 32'h3, 32'h0);
        push(32'h118, 32'h8003_0000, 32'h3, 32'hFFFF_FF80);
        neg();
        chk("lb_req", 32'(mif.mem_req), 32'h1);
        chk("lb_we", 32'(mif.mem_we), 32'h0);
        chk("lb_be", 32'(mif.mem_byteen), 32'h0);
        chk("lb_stall", 32'(stall), 32'h1);
        chk("lb_pend", 32'(fwd_pend), 32'h1);
        chk("lb_fvalid", 32'(fwd_valid), 32'h0);
        chk("lb_faddr", 32'(fwd_addr), 32'd3);
        nx();
        mif.mem_gnt = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            neg();
            chk("lb_w_stall", 32'(stall), 32'h1);
            chk("lb_w_req", 32'(mif.mem_req), 32'h0);
            chk("lb_w_pend", 32'(fwd_pend), 32'h1);
            nx();
        end
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata = 32'h80FF_FFFF;
        neg();
        chk("lb_rsp_stall", 32'(stall), 32'h0);

        nx();
        mif.mem_rvalid = 1'b0;
        drv(1'b1, 32'h11C, 32'h9003_0000, 32'h3, 32'h0);
        mif.mem_gnt = 1'b1;
        push(32'h11C, 32'h9003_0000, 32'h3, 32'h0000_0080);
        neg();
        chk("lbu_stall", 32'(stall), 32'h1);
        nx();
        mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b1;
        neg();
        chk("lbu_rsp_stall", 32'(stall), 32'h0);

        nx();
        mif.mem_rvalid = 1'b0;
        drv(1'b1, 32'h120, 32'h9403_0000, 32'h2, 32'h0);
        push(32'h120, 32'h9403_0000, 32'h2, 32'h0000_9234);
        for (int k = 1; k <= 2; k++) begin
            neg();
            chk("lhu_nogt_req", 32'(mif.mem_req), 32'h1);
            chk("lhu_nogt_stall", 32'(stall), 32'h1);
            nx();
        end
        mif.mem_gnt = 1'b1;
        neg();
        chk("lhu_gnt_req", 32'(mif.mem_req), 32'h1);
        nx();
        mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata = 32'h9234_5678;
        neg();
        chk("lhu_rsp_stall", 32'(stall), 32'h0);

        nx();
        mif.mem_rvalid = 1'b0;
        drv(1'b1, 32'h124, 32'h8403_0000, 32'h0, 32'h0);
        mif.mem_gnt = 1'b1;
        push(32'h124, 32'h8403_0000, 32'h0, 32'hFFFF_8001);
        nx();
        mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata = 32'h1234_8001;
        neg();
        chk("lh_rsp_stall", 32'(stall), 32'h0);

        nx();
        mif.mem_rvalid = 1'b0;
        drv(1'b1, 32'h128, 32'h8C03_0000, 32'h40, 32'h0);
        mif.mem_gnt = 1'b1;
        push(32'h128, 32'h8C03_0000, 32'h40, 32'h0);
        neg();
        chk("to_err_gnt", 32'(mem_err), 32'h0);
        nx();
        mif.mem_gnt = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            neg();
            chk("to_err", 32'(mem_err), 32'(k == 4));
            chk("to_stall", 32'(stall), 32'(k != 4));
            nx();
        end
        m_valid = 1'b0;
        neg();
        chk("to_err_after", 32'(mem_err), 32'h0);

        nx();
        drv(1'b1, 32'h12C, 32'h8003_0000, 32'h1, 32'h0);
        mif.mem_gnt = 1'b1;
        nx();
        mif.mem_gnt = 1'b0;
        neg();
        chk("fl_wait_stall", 32'(stall), 32'h1);
        nx();
        flush = 1'b1;
        neg();
        chk("fl_stall", 32'(stall), 32'h0);
        chk("fl_err", 32'(mem_err), 32'h0);
        nx();
        flush = 1'b0;
        m_valid = 1'b0;
        neg();
        chk("drain_stall", 32'(stall), 32'h1);
        nx();
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata = 32'h5555_5555;
        neg();
        chk("drain_rsp_stall", 32'(stall), 32'h1);
        chk("drain_err", 32'(mem_err), 32'h0);
        nx();
        mif.mem_rvalid = 1'b0;
        neg();
        chk("drain_done_stall", 32'(stall), 32'h0);
        chk("drain_wb_valid", 32'(wb_valid), 32'h0);

        nx();
        mif.mem_rvalid = 1'b1;
        nx();
        mif.mem_rvalid = 1'b0;
        neg();
        chk("stray_wb_valid", 32'(wb_valid), 32'h0);

        nx();
        drv(1'b1, 32'h130, 32'hAC02_0000, 32'h3000, 32'h1);
        flush = 1'b1;
        mif.mem_gnt = 1'b1;
        neg();
        chk("stfl_req", 32'(mif.mem_req), 32'h0);
        chk("stfl_be", 32'(mif.mem_byteen), 32'h0);
        chk("stfl_stall", 32'(stall), 32'h0);
        nx();
        flush = 1'b0;

        drv(1'b1, 32'h134, 32'h8C03_0008, 32'h8, 32'h0);
        nx();
        mif.mem_gnt = 1'b0;
        neg();
        chk("ar_wait_stall", 32'(stall), 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("ar_stall", 32'(stall), 32'h0);
        chk("ar_wb_valid", 32'(wb_valid), 32'h0);
        chk("ar_wb_pc", wb_pc, 32'h0000_3000);
        chk("ar_wb_alu", wb_alu_data, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        neg();
        chk("ar_idle_req", 32'(mif.mem_req), 32'h1);
        chk("ar_idle_addr", mif.mem_addr, 32'h8);
        chk("ar_idle_stall", 32'(stall), 32'h1);
        nx();
        m_valid = 1'b0;
        neg();
        chk("end_stall", 32'(stall), 32'h0);
        nx();
        neg();
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
